// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the AddSub8 round-robin arbiter.
package addsub_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

  // Saturation target chosen by the sign of operand a.
  function automatic logic [7:0] sat_value(input logic a_msb);
    return a_msb ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/AddSub8.sv
// Shared 8-bit two's-complement adder/subtractor with signed overflow flag.
module AddSub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       Sub,
  output logic [7:0] s,
  output logic       ovfl
);

  // Modular sum/difference; overflow when the signed result is not representable.
  always_comb begin
    s    = Sub ? (a - b) : (a + b);
    ovfl = Sub ? ((a[7] ^ b[7]) & (s[7] ^ a[7]))
               : (~(a[7] ^ b[7]) & (s[7] ^ a[7]));
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic        found;
  int unsigned cand;

  // Scan upward from ptr modulo N_REQ so unused id codes are never produced.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (32'(ptr) + off) % 32'(N_REQ);
      if (!found && req[ID_W'(cand)]) begin
        found               = 1'b1;
        gnt[ID_W'(cand)]    = 1'b1;
        gnt_id              = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one AddSub8 among N_REQ requesters.
// Optional macro ADDSUB_ARB_SAT_EN: saturate rsp_result on signed overflow.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]     req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_ovfl
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [7:0]        op_a, op_b;
  logic              op_sub;
  logic [ID_W-1:0]   op_id;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              accept;
  logic [7:0]        sum;
  logic              ovfl;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  AddSub8 u_addsub (
    .a    (op_a),
    .b    (op_b),
    .Sub  (op_sub),
    .s    (sum),
    .ovfl (ovfl)
  );

  assign accept = |(req_valid & req_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; grants are suppressed while reset is high.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) req_ready = gnt;
        if (|(req_valid & gnt)) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, result registration and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_ovfl   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a   <= req_a[{gnt_id, 3'b000} +: 8];
            op_b   <= req_b[{gnt_id, 3'b000} +: 8];
            op_sub <= req_sub[gnt_id];
            op_id  <= gnt_id;
          end
        end
        ST_EXEC: begin
`ifdef ADDSUB_ARB_SAT_EN
          rsp_result <= ovfl ? sat_value(op_a[7]) : sum;
`else
          rsp_result <= sum;
`endif
          rsp_ovfl   <= ovfl;
          rsp_id     <= op_id;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (op_id == ID_W'(N_REQ - 1)) rr_ptr <= '0;
            else                           rr_ptr <= op_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (N_REQ=4, ID_W=2).
module tb_addsub_arbiter;

  localparam int N = 4;

`ifdef ADDSUB_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_result;
  logic           rsp_ovfl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(
    .N_REQ (N),
    .ID_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovfl   (rsp_ovfl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation with rsp_ready held high; starts #1 after an edge in IDLE.
  task automatic run_op(input string tag, input int id, input logic [7:0] a,
                        input logic [7:0] b, input logic sub,
                        input logic [7:0] er, input logic eo);
    req_valid         = N'(1 << id);
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_sub[id]       = sub;
    rsp_ready         = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
    next_cyc();
    req_valid = '0;
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_exec_rdy"}, 32'(req_ready), 32'(0));
    next_cyc();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(1));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_res"}, 32'(rsp_result), 32'(er));
    chk({tag, "_ovfl"}, 32'(rsp_ovfl), 32'(eo));
    next_cyc();
    chk({tag, "_done"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    repeat (3) next_cyc();
    chk("rst_vld", 32'(rsp_valid), 32'(0));
    chk("rst_rdy", 32'(req_ready), 32'(0));
    chk("rst_id", 32'(rsp_id), 32'(0));
    chk("rst_res", 32'(rsp_result), 32'(0));
    chk("rst_ovfl", 32'(rsp_ovfl), 32'(0));
    rst = 1'b0;
    #1;

    // Directed arithmetic vectors (pointer walks 0->1->3->2->0->1->3).
    run_op("add0",   0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    run_op("ovadd2", 2, 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b1);
    run_op("ovsub1", 1, 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1);
    run_op("sub3",   3, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
    run_op("negov0", 0, 8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1);
    run_op("subn2",  2, 8'hC0, 8'h40, 1'b1, 8'h80, 1'b0);

    // Backpressure, valid dropping mid-op, operands changing before grant.
    req_valid    = 4'b0001;
    req_a[7:0]   = 8'h33;
    req_b[7:0]   = 8'h11;
    req_sub[0]   = 1'b0;
    rsp_ready    = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'(1));
    next_cyc();
    req_valid    = 4'b0010;
    req_a[15:8]  = 8'h01;
    req_b[15:8]  = 8'h01;
    req_sub[1]   = 1'b0;
    chk("bp_exec_rdy", 32'(req_ready), 32'(0));
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(rsp_valid), 32'(1));
      chk("bp_id", 32'(rsp_id), 32'(0));
      chk("bp_res", 32'(rsp_result), 32'(8'h44));
      chk("bp_rdy", 32'(req_ready), 32'(0));
      if (i == 2) begin
        req_a[15:8] = 8'h20;
        req_b[15:8] = 8'h02;
        req_sub[1]  = 1'b1;
      end
      next_cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_still_vld", 32'(rsp_valid), 32'(1));
    next_cyc();
    chk("bp_rel_vld", 32'(rsp_valid), 32'(0));
    chk("bp_rel_grant", 32'(req_ready), 32'(2));
    next_cyc();
    req_valid = '0;
    next_cyc();
    chk("chg_vld", 32'(rsp_valid), 32'(1));
    chk("chg_id", 32'(rsp_id), 32'(1));
    chk("chg_res", 32'(rsp_result), 32'(8'h1E));
    chk("chg_ovfl", 32'(rsp_ovfl), 32'(0));
    next_cyc();

    // Reset restores pointer to 0, then all requesters continuously valid.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = 8'((16 * i) + 1);
      req_b[8*i +: 8] = 8'(i);
      req_sub[i]      = 1'b0;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      next_cyc();
      chk("rr_exec_rdy", 32'(req_ready), 32'(0));
      next_cyc();
      chk("rr_vld", 32'(rsp_valid), 32'(1));
      chk("rr_id", 32'(rsp_id), 32'(g % 4));
      chk("rr_res", 32'(rsp_result), 32'((17 * (g % 4)) + 1));
      next_cyc();
    end

    // Reset during EXEC: operation for requester 1 is dropped.
    next_cyc();
    rst       = 1'b1;
    req_valid = '0;
    next_cyc();
    rst = 1'b0;
    chk("mid_vld", 32'(rsp_valid), 32'(0));
    chk("mid_res", 32'(rsp_result), 32'(0));
    chk("mid_id", 32'(rsp_id), 32'(0));
    chk("mid_rdy", 32'(req_ready), 32'(0));
    req_valid = '1;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'(1));
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      chk("mid_no_rsp", 32'(rsp_valid), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter that shares one existing AddSub8 8-bit two's-complement adder/subtractor among N_REQ requesters.
- Each requester presents operands and an add/sub select through a valid/ready handshake; the block grants one, sequences the operation through AddSub8, and returns a tagged result through a valid/ready response port.
- Sits between client blocks (sign changers, accumulators, display math) and the single shared AddSub8 instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal clog2(N_REQ), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept, one-hot or zero.
- req_a  input  8*N_REQ  operand a; requester i occupies bits [8i+7:8i].
- req_b  input  8*N_REQ  operand b, same packing as req_a.
- req_sub  input  N_REQ  1 = a-b, 0 = a+b.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of requester that owns the result.
- rsp_result  output  8  8-bit result.
- rsp_ovfl  output  1  signed overflow flag from AddSub8.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: synchronous, takes priority over all state activity.
  - state = IDLE, rr_ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_ovfl = 0, req_ready = 0.
  - Operand registers cleared.
  - Any in-flight operation is dropped; no response is ever issued for it.
- IDLE:
  - req_ready is combinational: one-hot to the first asserted req_valid, searching upward from rr_ptr with wrap-around; all zero if no req_valid.
  - On handshake (req_valid[g] & req_ready[g]), register a, b, sub and g into op_a, op_b, op_sub, op_id; go to EXEC.
- EXEC:
  - AddSub8 is driven from the op registers: a = op_a, b = op_b, Sub = op_sub.
  - Register its s and ovfl into rsp_result and rsp_ovfl; rsp_id = op_id; go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_result and rsp_ovfl are held stable until the handshake.
  - On rsp_ready: rsp_valid drops next cycle, rr_ptr = (op_id+1) mod N_REQ, go to IDLE.
  - req_ready = 0 throughout RESP.
- Latency: accept at cycle T; rsp_valid high at T+2; next accept no earlier than T+3 (rsp_ready held high gives one operation per 3 cycles).
- Arithmetic: 8-bit modular two's complement.
  - ovfl = 1 when the signed result is not representable.
  - Add: overflow when operand signs are equal and the result sign differs.
  - Sub (a-b): overflow when a and b signs differ and the result sign differs from a.
- Fairness: the winner becomes lowest priority. With all requesters continuously valid, grants rotate 0,1,2,3,0,…
- Boundary conditions:
  - req_valid deasserting in EXEC/RESP has no effect; the captured operation completes.
  - A request held with changing operands before grant: only the operands in the accept cycle are used.
  - N_REQ not a power of two: pointer wrap goes from N_REQ-1 to 0; unused id codes are never produced.
  - rsp_ready high in the same cycle rsp_valid first rises completes the handshake that cycle.

Optional Feature:
- Macro: ADDSUB_ARB_SAT_EN.
- Defined: when ovfl = 1, rsp_result is replaced by a saturated value captured in EXEC: 8'h80 if op_a[7] = 1, else 8'h7F. rsp_ovfl is still reported as 1.
- Undefined: rsp_result is the raw wrapped AddSub8 sum; no saturation logic is present.

Decomposition:
- Shared package (addsub_arb_pkg): state encoding constants ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2; saturation constants SAT_POS = 8'h7F, SAT_NEG = 8'h80.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: request vector, rr_ptr. Output: one-hot grant plus encoded index.
- AddSub8 is instantiated unchanged as the shared datapath.

Test Plan:
- Single add: req0 a=8'h05, b=8'h03, sub=0, accepted at T -> at T+2 rsp_valid=1, rsp_id=0, rsp_result=8'h08, rsp_ovfl=0.
- Overflow: req2 a=8'h7F, b=8'h01, add -> rsp_result=8'h80 and rsp_ovfl=1; with ADDSUB_ARB_SAT_EN, rsp_result=8'h7F and rsp_ovfl=1.
- Subtract: req1 a=8'h80, b=8'h01, sub=1 -> raw rsp_result=8'h7F, rsp_ovfl=1; with ADDSUB_ARB_SAT_EN, rsp_result=8'h80.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, with each accept 3 cycles after the previous.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result remain stable and req_ready stays 0; release -> IDLE next cycle.
- Reset mid-op: rst asserted during EXEC -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0; the dropped operation never appears on the response port.
